// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX and RX sides: frame states,
// data width and the default baud divisor for 115200 baud at the system clock.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int SYS_CLK_HZ = 100_000_000;
  localparam int BAUD_RATE  = 115_200;

  // Rounded to the nearest clock: 868 at 100 MHz.
  localparam int CLKS_PER_BIT_115200 = (SYS_CLK_HZ + BAUD_RATE / 2) / BAUD_RATE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK
  } uart_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sfifo.sv
// Synchronous show-ahead FIFO: rd_data always presents the head entry and reads
// as zero while empty. A push into a full FIFO succeeds only alongside a pop.
module uart_rx_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNTW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the empty gating on rd_data hides stale entries.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a
// show-ahead byte FIFO with sticky overrun / framing / parity status flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int FIFO_DEPTH   = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rxd,
  input  logic                        rd_pop,
  input  logic                        err_clr,
  output logic [DATA_BITS-1:0]        rd_data,
  output logic                        rd_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        overrun,
  output logic                        frame_err,
  output logic                        parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxs;
  logic                   rxs_prev_q;
  logic                   rxs_fall;

  uart_state_e            state_q;
  logic [CW-1:0]          baud_cnt_q;
  logic [IW-1:0]          bit_idx_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic                   baud_zero;

  logic                   push;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   frame_evt;
  logic                   overrun_evt;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;

  // RXD synchroniser, preset to the idle level so reset never fakes a start bit.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= sync_d;
      rxs_prev_q <= rxs;
    end
  end

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign rxs_fall  = rxs_prev_q && !rxs;
  assign baud_zero = (baud_cnt_q == '0);
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rxs_fall) begin
            baud_cnt_q <= HALF_BIT;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (!baud_zero) begin
            baud_cnt_q <= baud_cnt_q - 1'b1;
          end else if (!rxs) begin
            baud_cnt_q <= FULL_BIT;
            bit_idx_q  <= '0;
            state_q    <= ST_DATA;
          end else begin
            state_q    <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (!baud_zero) begin
            baud_cnt_q <= baud_cnt_q - 1'b1;
          end else begin
            shreg_q    <= {rxs, shreg_q[DATA_BITS-1:1]};
            baud_cnt_q <= FULL_BIT;
            if (bit_idx_q == IW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (!baud_zero) begin
            baud_cnt_q <= baud_cnt_q - 1'b1;
          end else begin
            baud_cnt_q <= FULL_BIT;
            state_q    <= ST_STOP;
          end
        end
`endif
        // Leaving at mid-stop lets the next start edge be seen immediately.
        ST_STOP: begin
          if (!baud_zero) begin
            baud_cnt_q <= baud_cnt_q - 1'b1;
          end else if (rxs) begin
            state_q    <= ST_IDLE;
          end else begin
            state_q    <= ST_BRK;
          end
        end
        ST_BRK: begin
          if (rxs) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign push        = (state_q == ST_STOP) && baud_zero && rxs;
  assign frame_evt   = (state_q == ST_STOP) && baud_zero && !rxs;
  assign overrun_evt = push && fifo_full && !rd_pop;

  uart_rx_sfifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (shreg_q),
    .pop     (rd_pop),
    .rd_data (rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rd_valid = !fifo_empty;

  // Sticky flags: a set event in the clear cycle takes priority.
  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (err_clr) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (overrun_evt) overrun_d   = 1'b1;
    if (frame_evt)   frame_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

`ifdef UART_RX_PARITY_EN
  logic parity_evt;
  logic parity_err_q, parity_err_d;

  assign parity_evt = (state_q == ST_PARITY) && baud_zero &&
                      (rxs != even_parity(shreg_q));

  always_comb begin
    parity_err_d = parity_err_q;
    if (err_clr)    parity_err_d = 1'b0;
    if (parity_evt) parity_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with CLKS_PER_BIT=8 and FIFO_DEPTH=4.
module tb_uart_rx_fifo;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       rd_pop;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       busy;
  logic       overrun;
  logic       frame_err;
  logic       parity_err;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .SYNC_STAGES  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .rd_pop     (rd_pop),
    .err_clr    (err_clr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .busy       (busy),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Start bit, data LSB first, and the parity bit when the frame carries one.
  task automatic send_head(input logic [7:0] d);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`endif
  endtask

  // The stop sample lands 6 clocks into the stop bit, so a pop raised there
  // coincides with the push.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pop_on_push);
    send_head(d);
    if (pop_on_push) begin
      rxd = stop;
      repeat (CPB - 2) @(posedge clk);
      #1 rd_pop = 1'b1;
      @(posedge clk);
      #1 rd_pop = 1'b0;
      @(posedge clk);
      #1;
    end else begin
      drive_bit(stop);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk(tag, rd_data, exp);
    rd_pop = 1'b1;
    @(posedge clk);
    #1 rd_pop = 1'b0;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    rxd     = 1'b1;
    rd_pop  = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid",  rd_valid,   1'b0);
    chk("rst_count",  fifo_count, 3'd0);
    chk("rst_busy",   busy,       1'b0);
    chk("rst_data",   rd_data,    8'h00);
    chk("rst_ovr",    overrun,    1'b0);
    chk("rst_ferr",   frame_err,  1'b0);
    chk("rst_perr",   parity_err, 1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single byte with exact latency around the mid-stop sample
    send_head(8'hA5);
    rxd = 1'b1;
    repeat (CPB - 2) @(posedge clk);
    @(negedge clk);
    chk("a5_not_yet", rd_valid, 1'b0);
    @(negedge clk);
    chk("a5_valid", rd_valid,   1'b1);
    chk("a5_data",  rd_data,    8'hA5);
    chk("a5_count", fifo_count, 3'd1);
    chk("a5_idle",  busy,       1'b0);
    rd_pop = 1'b1;
    @(posedge clk);
    #1 rd_pop = 1'b0;
    @(negedge clk);
    chk("a5_popped", rd_valid,   1'b0);
    chk("a5_cnt0",   fifo_count, 3'd0);
    @(posedge clk);
    #1;

    // Glitch shorter than half a bit
    rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd = 1'b1;
    @(negedge clk);
    chk("glitch_busy", busy, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("glitch_idle",  busy,       1'b0);
    chk("glitch_count", fifo_count, 3'd0);
    chk("glitch_ferr",  frame_err,  1'b0);
    chk("glitch_ovr",   overrun,    1'b0);
    @(posedge clk);
    #1;

    // Overrun: five back-to-back frames into a depth-4 FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    @(negedge clk);
    chk("ovr_count", fifo_count, 3'd4);
    chk("ovr_flag",  overrun,    1'b1);
    chk("ovr_ferr",  frame_err,  1'b0);
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    chk("ovr_clr", overrun, 1'b0);
    pop_chk("ovr_b1", 8'h01);
    pop_chk("ovr_b2", 8'h02);
    pop_chk("ovr_b3", 8'h03);
    pop_chk("ovr_b4", 8'h04);
    @(negedge clk);
    chk("ovr_empty", fifo_count, 3'd0);
    @(posedge clk);
    #1;

    // Framing error followed by a held-low break
    send_frame(8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    chk("fe_flag",  frame_err,  1'b1);
    chk("fe_brk",   busy,       1'b1);
    chk("fe_count", fifo_count, 3'd0);
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    repeat (38) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("brk_once",  frame_err,  1'b0);
    chk("brk_idle",  busy,       1'b0);
    chk("brk_count", fifo_count, 3'd0);
    @(posedge clk);
    #1;
    send_frame(8'h77, 1'b1, 1'b0);
    @(negedge clk);
    chk("brk_next_cnt", fifo_count, 3'd1);
    pop_chk("brk_next", 8'h77);

    // Simultaneous push and pop while full
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
    @(negedge clk);
    chk("sim_full", fifo_count, 3'd4);
    chk("sim_head", rd_data,    8'h10);
    @(posedge clk);
    #1;
    send_frame(8'h14, 1'b1, 1'b1);
    @(negedge clk);
    chk("sim_count", fifo_count, 3'd4);
    chk("sim_ovr",   overrun,    1'b0);
    pop_chk("sim_b1", 8'h11);
    pop_chk("sim_b2", 8'h12);
    pop_chk("sim_b3", 8'h13);
    pop_chk("sim_b4", 8'h14);
    @(negedge clk);
    chk("sim_empty", fifo_count, 3'd0);
    @(posedge clk);
    #1;

    // Reset during data bit 4, with a byte already buffered
    send_frame(8'h5A, 1'b1, 1'b0);
    @(negedge clk);
    chk("mid_pre_cnt", fifo_count, 3'd1);
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rxd = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    rxd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_busy",  busy,       1'b0);
    chk("mid_count", fifo_count, 3'd0);
    chk("mid_valid", rd_valid,   1'b0);
    chk("mid_data",  rd_data,    8'h00);
    chk("mid_ferr",  frame_err,  1'b0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_frame(8'hC3, 1'b1, 1'b0);
    @(negedge clk);
    chk("mid_next_cnt", fifo_count, 3'd1);
    chk("mid_next_ferr", frame_err, 1'b0);
    pop_chk("mid_next", 8'hC3);

`ifdef UART_RX_PARITY_EN
    // Wrong parity bit still delivers the byte
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    par_flip = 1'b0;
    @(negedge clk);
    chk("par_flag",  parity_err, 1'b1);
    chk("par_count", fifo_count, 3'd1);
    pop_chk("par_data", 8'h07);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
